// File: rtl/serial_add_4bit.sv
// ---------------------------------------------------------------------------
// serial_add_4bit
//
// Bit-serial adder with valid/ready handshakes on both sides. Operands are
// captured on accept, then one full-adder bit is evaluated per clock, LSB
// first. After WIDTH cycles the sum, unsigned carry out and signed overflow
// are presented and held until the consumer takes them.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   A/B are valid this cycle
//   in_ready   block can accept operands (only while idle)
//   A, B       WIDTH-bit addends (unsigned or two's complement)
//   out_valid  S/Cout/Ovf hold a completed result
//   out_ready  consumer takes the result this cycle
//   S          A+B modulo 2^WIDTH
//   Cout       carry out of the MSB
//   Ovf        signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_add_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q, b_d;      // operand B, shifted right each RUN cycle
  logic [WIDTH-1:0] sh_q, sh_d;    // partial sum, filled from the MSB end
  logic [WIDTH-1:0] s_q, s_d;      // published sum
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One full-adder bit on the current LSBs.
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   sh_ext;
  logic [WIDTH-1:0] sh_next;

  assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);

  // The new sum bit enters at the MSB; after WIDTH shifts bit 0 of the sum
  // has reached position 0.
  assign sh_ext  = {fa_sum, sh_q};
  assign sh_next = sh_ext[WIDTH:1];

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          sh_d    = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // A/B inputs are not looked at here: the result depends only on the
        // captured copies.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_next;
        carry_d = fa_carry;
        if (cnt_q == LAST_BIT) begin
          // Final bit: carry_q is the carry into the MSB, fa_carry the carry
          // out of it. The counter parks at LAST_BIT rather than wrapping.
          s_d     = sh_next;
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        // S/Cout/Ovf are untouched here, so they hold under backpressure and
        // keep the last result through the following IDLE period.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        // Encoding 2'b11 is unreachable; fall back to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: all of these are individual flops (no memory arrays), so each one
  // is cleared by the asynchronous reset; a reset mid-operation therefore
  // drops the in-flight result completely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: handshake flags are pure state decodes, with no combinational
  // path from any input.
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: doc/serial_add_4bit.md
SERIAL_ADD_4BIT -- requirements
Module: serial_add_4bit

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits; the bench exercises the default only.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is synchronised externally.
REQ-004 in_valid  input  1  operands A and B are valid this cycle.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 A  input  WIDTH  addend, unsigned or two's complement.
REQ-007 B  input  WIDTH  addend, unsigned or two's complement.
REQ-008 out_valid  output  1  S, Cout and Ovf hold a completed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 S  output  WIDTH  sum A+B modulo 2^WIDTH.
REQ-011 Cout  output  1  unsigned carry out of the MSB.
REQ-012 Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 Three-state FSM: IDLE, RUN, DONE; IDLE is the reset state.
REQ-014 in_ready SHALL be 1 only in IDLE, decoded from state with no combinational path from any input.
REQ-015 Accept happens at the edge where in_valid=1 and in_ready=1: A and B are captured into internal shift registers, the carry register is cleared to 0, the bit counter is set to 0, and the FSM goes to RUN.
REQ-016 In RUN, each edge computes one full-adder bit, LSB first: sum = a^b^c, carry = (a&b)|((a^b)&c); the sum bit shifts into the result register and the carry register updates.
REQ-017 Bit i is processed at edge k+1+i after an accept at edge k; after edge k+WIDTH the FSM is in DONE and out_valid=1, giving a latency of WIDTH cycles from accept.
REQ-018 Ovf SHALL be latched from (carry into MSB) XOR (carry out of MSB) at the final RUN edge.
REQ-019 In DONE, S, Cout and Ovf SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 At the edge where out_valid=1 and out_ready=1, the FSM goes to IDLE and out_valid drops; in_ready rises the following cycle, so a new accept cannot occur in the same cycle as result transfer.
REQ-021 S, Cout and Ovf SHALL retain the last result in IDLE until the next result overwrites them; out_valid is the only qualifier of validity.
REQ-022 in_valid, A and B SHALL be ignored in RUN and DONE, and operand changes during RUN SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 The FSM SHALL advance RUN->DONE on the counter reaching WIDTH-1; the counter SHALL NOT wrap into a second pass.
REQ-025 Unreachable state encodings SHALL recover to IDLE on the next edge.
REQ-026 Throughput SHALL be one result per WIDTH+2 cycles when out_ready is held at 1.

Reset
REQ-027 While rst_n=0: FSM=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, Ovf=0, carry, counter and shift registers all 0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered; after release the block accepts new operands normally.
REQ-029 Release of rst_n SHALL cause no spurious accept unless in_valid=1 at the first active edge.

Verification
REQ-030 A=3, B=5, out_ready=1 -> out_valid exactly 4 cycles after accept; S=8, Cout=0, Ovf=1.
REQ-031 A=15, B=1 -> S=0, Cout=1, Ovf=0; A=8, B=8 -> S=0, Cout=1, Ovf=1; A=7, B=7 -> S=14, Cout=0, Ovf=1.
REQ-032 A=6, B=9 with out_ready=0 for 5 cycles after out_valid -> S=15, Cout=0, Ovf=0 stable throughout; in_ready=0 until the cycle after the out_ready=1 transfer.
REQ-033 in_valid held at 1 with A=2, B=2, then A/B changed to 9/9 during RUN -> result S=4; exactly one accept per IDLE visit.
REQ-034 rst_n pulsed low at the second RUN cycle of A=5, B=6 -> all outputs 0 immediately and no out_valid; a subsequent A=5, B=6 yields S=11, Cout=0, Ovf=1.
REQ-035 Exhaustive sweep of all 256 A/B pairs with random out_ready backpressure -> S, Cout and Ovf match a reference model for every pair.
